// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types and constants for the 4-input round-robin arbiter and its mux.
package mux4_rr_arbiter_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_e;

    function automatic logic [N_REQ-1:0] to_onehot(input logic [SEL_W-1:0] idx);
        logic [N_REQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/mux4.sv
// Plain 4:1 single-bit multiplexer steered by a binary select.
module mux4 (
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       d,
    input  logic [1:0] sel,
    output logic       muxout
);

    always_comb begin
        muxout = a;
        case (sel)
            2'd0: muxout = a;
            2'd1: muxout = b;
            2'd2: muxout = c;
            2'd3: muxout = d;
            default: muxout = a;
        endcase
    end

endmodule

// File: rtl/rr_pick4.sv
// Combinational round-robin pick: first set request after last, wrapping to last itself.
module rr_pick4
    import mux4_rr_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] last,
    output logic [SEL_W-1:0] winner,
    output logic             any
);

    always_comb begin
        logic [SEL_W-1:0] idx;
        winner = last;
        any    = |req;
        // Scan farthest-first so the nearest successor of last overwrites.
        for (int j = N_REQ; j >= 1; j--) begin
            idx = last + SEL_W'(j);
            if (req[idx]) begin
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter with hold-time preemption driving a 4:1 mux select.
module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int HOLD_MAX = 16,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic [SEL_W-1:0] sel,
    output logic             sel_valid,
    output logic [CNT_W-1:0] hold_cnt,
    output logic             muxout
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

    state_e           state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] last_q, last_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] hold_q, hold_d;

    logic [SEL_W-1:0] winner;
    logic             any;
    logic             at_max;
    logic             rivals;
    logic             retain;

    rr_pick4 u_pick (
        .req    (req),
        .last   (last_q),
        .winner (winner),
        .any    (any)
    );

    assign at_max = (hold_q == HOLD_LAST);
    assign rivals = |(req & ~grant_q);
    assign retain = (state_q == OWN) && req[sel_q] && !(at_max && rivals);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        last_d  = last_q;
        valid_d = valid_q;
        hold_d  = hold_q;
        unique case (1'b1)
            retain: begin
                hold_d = at_max ? '0 : hold_q + CNT_W'(1);
            end
            !retain && any: begin
                state_d = OWN;
                grant_d = to_onehot(winner);
                sel_d   = winner;
                last_d  = winner;
                valid_d = 1'b1;
                hold_d  = '0;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                valid_d = 1'b0;
                hold_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            sel_q   <= '0;
            last_q  <= SEL_W'(N_REQ - 1);
            valid_q <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            hold_q  <= hold_d;
        end
    end

    assign grant     = grant_q;
    assign sel       = sel_q;
    assign sel_valid = valid_q;
    assign hold_cnt  = hold_q;

    mux4 u_mux (
        .a      (req[0]),
        .b      (req[1]),
        .c      (req[2]),
        .d      (req[3]),
        .sel    (sel_q),
        .muxout (muxout)
    );

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboard bench: HOLD_MAX=4 and HOLD_MAX=1 arbiters share req/rst.
module tb_mux4_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;

    logic [3:0] g0, g1;
    logic [1:0] s0, s1;
    logic       v0, v1;
    logic [7:0] h0, h1;
    logic       m0, m1;

    always #5 clk = ~clk;

    mux4_rr_arbiter #(.HOLD_MAX(4), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .req(req), .grant(g0), .sel(s0),
        .sel_valid(v0), .hold_cnt(h0), .muxout(m0)
    );

    mux4_rr_arbiter #(.HOLD_MAX(1), .CNT_W(8)) u_dut1 (
        .clk(clk), .rst(rst), .req(req), .grant(g1), .sel(s1),
        .sel_valid(v1), .hold_cnt(h1), .muxout(m1)
    );

    typedef struct {
        logic [3:0] g;
        logic [1:0] s;
        logic       v;
        logic [7:0] h;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int n_run  = 0;
    int n_fail = 0;

    int hm[2]     = '{4, 1};
    int m_own[2]  = '{0, 0};
    int m_last[2] = '{3, 3};
    int m_hold[2] = '{0, 0};
    int m_sel[2]  = '{0, 0};
    int w0[4]     = '{0, 0, 0, 0};
    int w1[4]     = '{0, 0, 0, 0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic predict(input int k, input logic [3:0] r, input logic rs, output exp_t e);
        logic [3:0] mine;
        logic       keep;
        logic       found;
        int         idx;
        if (rs) begin
            m_own[k]  = 0;
            m_last[k] = 3;
            m_hold[k] = 0;
            m_sel[k]  = 0;
        end else begin
            mine = 4'b0001 << m_last[k];
            keep = (m_own[k] != 0) && r[m_last[k]] &&
                   !((m_hold[k] == hm[k] - 1) && ((r & ~mine) != 4'b0));
            if (keep) begin
                m_hold[k] = (m_hold[k] == hm[k] - 1) ? 0 : m_hold[k] + 1;
            end else if (r != 4'b0) begin
                found = 1'b0;
                for (int j = 1; j <= 4; j++) begin
                    idx = (m_last[k] + j) % 4;
                    if (!found && r[idx]) begin
                        found     = 1'b1;
                        m_last[k] = idx;
                    end
                end
                m_own[k]  = 1;
                m_sel[k]  = m_last[k];
                m_hold[k] = 0;
            end else begin
                m_own[k]  = 0;
                m_hold[k] = 0;
            end
        end
        e.g = (m_own[k] != 0) ? (4'b0001 << m_last[k]) : 4'b0000;
        e.s = 2'(m_sel[k]);
        e.v = (m_own[k] != 0);
        e.h = 8'(m_hold[k]);
    endtask

    task automatic step(input logic [3:0] r, input logic rs);
        exp_t e;
        int   mx0;
        int   mx1;
        req = r;
        rst = rs;
        predict(0, r, rs, e);
        q0.push_back(e);
        predict(1, r, rs, e);
        q1.push_back(e);
        @(posedge clk);
        @(negedge clk);
        e = q0.pop_front();
        check("grant0", 32'(g0), 32'(e.g));
        check("sel0", 32'(s0), 32'(e.s));
        check("valid0", 32'(v0), 32'(e.v));
        check("hold0", 32'(h0), 32'(e.h));
        check("mux0", 32'(m0), 32'(r[e.s]));
        e = q1.pop_front();
        check("grant1", 32'(g1), 32'(e.g));
        check("sel1", 32'(s1), 32'(e.s));
        check("valid1", 32'(v1), 32'(e.v));
        check("hold1", 32'(h1), 32'(e.h));
        check("onehot0", 32'($onehot0(g0) && $onehot0(g1)), 32'd1);
        if (v0) check("selmatch0", 32'(g0), 32'(4'b0001 << s0));
        mx0 = 0;
        mx1 = 0;
        for (int i = 0; i < 4; i++) begin
            w0[i] = (!rs && r[i] && !g0[i]) ? w0[i] + 1 : 0;
            w1[i] = (!rs && r[i] && !g1[i]) ? w1[i] + 1 : 0;
            if (w0[i] > mx0) mx0 = w0[i];
            if (w1[i] > mx1) mx1 = w1[i];
        end
        check("wait0", 32'(mx0 <= 3 * 4), 32'd1);
        check("wait1", 32'(mx1 <= 3 * 1), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] r;
        req = 4'b0;
        rst = 1'b1;
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);
        check("rst_grant", 32'(g0), 32'd0);
        check("rst_sel", 32'(s0), 32'd0);

        step(4'b0110, 1'b0);
        check("first_grant", 32'(g0), 32'h2);
        check("first_sel", 32'(s0), 32'd1);
        check("first_valid", 32'(v0), 32'd1);
        step(4'b0110, 1'b0);
        step(4'b0100, 1'b0);
        check("handoff_grant", 32'(g0), 32'h4);
        check("handoff_sel", 32'(s0), 32'd2);
        step(4'b0000, 1'b0);
        check("release_idle", 32'(v0), 32'd0);
        check("idle_sel_hold", 32'(s0), 32'd2);

        step(4'b0000, 1'b1);
        for (int i = 0; i < 12; i++) begin
            step(4'b1001, 1'b0);
            check("alt_grant", 32'(g0), ((i / 4) % 2 == 1) ? 32'h8 : 32'h1);
            check("alt_hold", 32'(h0), 32'(i % 4));
        end

        step(4'b0000, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step(4'b1000, 1'b0);
            check("solo_grant", 32'(g0), 32'h8);
            check("solo_hold", 32'(h0), 32'(i % 4));
        end

        step(4'b0000, 1'b1);
        step(4'b0100, 1'b0);
        check("pre_rst_grant", 32'(g0), 32'h4);
        step(4'b1111, 1'b1);
        check("rst_drop_grant", 32'(g0), 32'd0);
        check("rst_drop_sel", 32'(s0), 32'd0);
        check("rst_drop_valid", 32'(v0), 32'd0);
        step(4'b1111, 1'b0);
        check("post_rst_grant", 32'(g0), 32'h1);

        step(4'b0000, 1'b1);
        for (int i = 0; i < 8; i++) begin
            step(4'b1111, 1'b0);
            check("rot1_grant", 32'(g1), 32'(4'b0001 << (i % 4)));
        end

        r = 4'b0000;
        for (int n = 0; n < 10000; n++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 7) == 0) r[i] = ~r[i];
            end
            step(r, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
